// File: rtl/mdc_input_commutator_if.sv
// Stream bundle between the sample source and the MDC input commutator:
// one serial complex input plus the upper/lower parallel outputs.
interface mdc_input_commutator_if #(
  parameter int DATA_W = 13
);
  logic                     mode;
  logic signed [DATA_W-1:0] in0_re;
  logic signed [DATA_W-1:0] in0_im;
  logic signed [DATA_W-1:0] Up_out_re;
  logic signed [DATA_W-1:0] Up_out_im;
  logic signed [DATA_W-1:0] Low_out_re;
  logic signed [DATA_W-1:0] Low_out_im;

  modport master (
    output mode, in0_re, in0_im,
    input  Up_out_re, Up_out_im, Low_out_re, Low_out_im
  );

  modport slave (
    input  mode, in0_re, in0_im,
    output Up_out_re, Up_out_im, Low_out_re, Low_out_im
  );
endinterface

// File: rtl/mdc_input_commutator.sv
// Radix-2 MDC FFT input commutator: pairs x[n] (upper) with x[n+N/2] (lower).
// Define COMMUTATOR_OUT_REG_EN to add one extra output register stage.
module mdc_input_commutator #(
  parameter int DATA_W = 13,
  parameter int N_MAX  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  mdc_input_commutator_if.slave bus
);
  localparam int DEPTH = N_MAX / 2;
  localparam int CNT_W = $clog2(N_MAX);
  localparam int IDX_W = $clog2(DEPTH);

  logic [CNT_W-1:0]         r_cnt;
  logic                     r_mode;
  logic signed [DATA_W-1:0] r_dly_re [DEPTH];
  logic signed [DATA_W-1:0] r_dly_im [DEPTH];
  logic signed [DATA_W-1:0] r_up_re_p0, r_up_im_p0, r_low_re_p0, r_low_im_p0;

  logic [CNT_W-1:0]         w_half;
  logic [CNT_W-1:0]         w_last;
  logic [IDX_W-1:0]         w_tap_idx;
  logic                     w_upper;
  logic signed [DATA_W-1:0] w_tap_re, w_tap_im;

  // The tap is read before this edge's shift, so depth H sits at index H-1.
  always_comb begin
    w_half    = r_mode ? CNT_W'(N_MAX / 4)     : CNT_W'(N_MAX / 2);
    w_last    = r_mode ? CNT_W'(N_MAX / 2 - 1) : CNT_W'(N_MAX - 1);
    w_tap_idx = r_mode ? IDX_W'(DEPTH / 2 - 1) : IDX_W'(DEPTH - 1);
    w_upper   = (r_cnt >= w_half);
    w_tap_re  = r_dly_re[w_tap_idx];
    w_tap_im  = r_dly_im[w_tap_idx];
  end

  // Control: sample counter; mode only changes at a frame boundary or reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_mode <= bus.mode;
    end else if (r_cnt == w_last) begin
      r_cnt  <= '0;
      r_mode <= bus.mode;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  // Stage p0: delay line and commutated output pair
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_dly_re[i] <= '0;
        r_dly_im[i] <= '0;
      end
      r_up_re_p0  <= '0;
      r_up_im_p0  <= '0;
      r_low_re_p0 <= '0;
      r_low_im_p0 <= '0;
    end else begin
      r_dly_re[0] <= bus.in0_re;
      r_dly_im[0] <= bus.in0_im;
      for (int i = 1; i < DEPTH; i++) begin
        r_dly_re[i] <= r_dly_re[i-1];
        r_dly_im[i] <= r_dly_im[i-1];
      end
      if (w_upper) begin
        r_up_re_p0  <= w_tap_re;
        r_up_im_p0  <= w_tap_im;
        r_low_re_p0 <= bus.in0_re;
        r_low_im_p0 <= bus.in0_im;
      end else begin
        r_up_re_p0  <= '0;
        r_up_im_p0  <= '0;
        r_low_re_p0 <= '0;
        r_low_im_p0 <= '0;
      end
    end
  end

`ifdef COMMUTATOR_OUT_REG_EN
  logic signed [DATA_W-1:0] r_up_re_p1, r_up_im_p1, r_low_re_p1, r_low_im_p1;

  // Stage p1: retiming register on all four outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_up_re_p1  <= '0;
      r_up_im_p1  <= '0;
      r_low_re_p1 <= '0;
      r_low_im_p1 <= '0;
    end else begin
      r_up_re_p1  <= r_up_re_p0;
      r_up_im_p1  <= r_up_im_p0;
      r_low_re_p1 <= r_low_re_p0;
      r_low_im_p1 <= r_low_im_p0;
    end
  end

  assign bus.Up_out_re  = r_up_re_p1;
  assign bus.Up_out_im  = r_up_im_p1;
  assign bus.Low_out_re = r_low_re_p1;
  assign bus.Low_out_im = r_low_im_p1;
`else
  assign bus.Up_out_re  = r_up_re_p0;
  assign bus.Up_out_im  = r_up_im_p0;
  assign bus.Low_out_re = r_low_re_p0;
  assign bus.Low_out_im = r_low_im_p0;
`endif

endmodule

// File: tb/tb_mdc_input_commutator.sv
// Scoreboard bench for mdc_input_commutator: the driver queues the expected
// output pair per edge, a negedge monitor pops and compares.
module tb_mdc_input_commutator;
  localparam int DW = 13;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdc_input_commutator_if #(.DATA_W(DW)) bus ();

  mdc_input_commutator #(.DATA_W(DW), .N_MAX(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic signed [DW-1:0] ur;
    logic signed [DW-1:0] ui;
    logic signed [DW-1:0] lr;
    logic signed [DW-1:0] li;
    string                name;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  exp_t e_prev;
  int   n_chk  = 0;
  int   n_pass = 0;

  logic signed [DW-1:0] fr_re   [64];
  logic signed [DW-1:0] fr_im   [64];
  logic                 fr_mode [64];

  function automatic exp_t mk(input logic signed [DW-1:0] ur, ui, lr, li,
                              input string n);
    exp_t e;
    e.ur = ur; e.ui = ui; e.lr = lr; e.li = li; e.name = n;
    return e;
  endfunction

  // Expected values become visible after the edge that samples the input
  task automatic step(input logic r, input logic m,
                      input logic signed [DW-1:0] ir, ii, input exp_t e);
    rst = r; bus.mode = m; bus.in0_re = ir; bus.in0_im = ii;
    @(posedge clk);
`ifdef COMMUTATOR_OUT_REG_EN
    sb.push_back(e_prev);
    e_prev = e;
`else
    sb.push_back(e);
`endif
    #1;
  endtask

  task automatic do_reset(input logic m, input int cycles, input string tag);
    for (int c = 0; c < cycles; c++)
      step(1'b1, m, DW'(7), DW'(-7), mk('0, '0, '0, '0, $sformatf("%s_rst%0d", tag, c)));
  endtask

  task automatic fill_ramp(input int base, input int n, input logic m);
    for (int k = 0; k < n; k++) begin
      fr_re[k]   = DW'(base + k);
      fr_im[k]   = DW'(-(base + k));
      fr_mode[k] = m;
    end
  endtask

  // First h edges give zeros, then x[k-h] on the upper and x[k] on the lower path
  task automatic run_frame(input int n, input int h, input string tag);
    for (int k = 0; k < n; k++) begin
      if (k < h)
        step(1'b0, fr_mode[k], fr_re[k], fr_im[k],
             mk('0, '0, '0, '0, $sformatf("%s_zero%0d", tag, k)));
      else
        step(1'b0, fr_mode[k], fr_re[k], fr_im[k],
             mk(fr_re[k-h], fr_im[k-h], fr_re[k], fr_im[k],
                $sformatf("%s_pair%0d", tag, k - h)));
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e_mon = sb.pop_front();
      n_chk++;
      if (bus.Up_out_re === e_mon.ur && bus.Up_out_im === e_mon.ui &&
          bus.Low_out_re === e_mon.lr && bus.Low_out_im === e_mon.li)
        n_pass++;
      else
        $display("FAIL %s: got up=(%0d,%0d) low=(%0d,%0d), expected up=(%0d,%0d) low=(%0d,%0d)",
                 e_mon.name, bus.Up_out_re, bus.Up_out_im, bus.Low_out_re, bus.Low_out_im,
                 e_mon.ur, e_mon.ui, e_mon.lr, e_mon.li);
    end
  end

  initial begin
    e_prev = mk('0, '0, '0, '0, "pipe_fill");

    // Reset held with a nonzero input, then a 32-point ramp frame
    do_reset(1'b0, 2, "t1");
    fill_ramp(0, 32, 1'b0);
    run_frame(32, 16, "t2");

    // 16-point frame, mode latched by reset
    do_reset(1'b1, 1, "t3");
    fill_ramp(0, 16, 1'b1);
    run_frame(16, 8, "t3");

    // Two back-to-back 32-point frames
    do_reset(1'b0, 1, "t4");
    fill_ramp(0, 32, 1'b0);
    run_frame(32, 16, "t4f1");
    fill_ramp(100, 32, 1'b0);
    run_frame(32, 16, "t4f2");

    // Reset asserted at cnt=20, then a fresh frame
    do_reset(1'b0, 1, "t5");
    fill_ramp(0, 20, 1'b0);
    run_frame(20, 16, "t5pre");
    step(1'b1, 1'b0, DW'(33), DW'(-33), mk('0, '0, '0, '0, "t5_midrst"));
    fill_ramp(200, 32, 1'b0);
    run_frame(32, 16, "t5post");

    // Extremes with mode raised mid-frame: this frame stays 32-point
    do_reset(1'b0, 1, "t6");
    for (int k = 0; k < 32; k++) begin
      fr_re[k]   = (k % 2 == 1) ? DW'(4095)  : DW'(-4096);
      fr_im[k]   = (k % 2 == 1) ? DW'(-4096) : DW'(4095);
      fr_mode[k] = (k >= 5);
    end
    run_frame(32, 16, "t6a");
    // Next frame is 16-point, with extremes at both ends
    fill_ramp(50, 16, 1'b1);
    fr_re[0]  = DW'(-4096);
    fr_im[15] = DW'(4095);
    run_frame(16, 8, "t6b");
    // A 17th sample starts a new frame, so it must produce zeros
    step(1'b0, 1'b0, DW'(1), DW'(1), mk('0, '0, '0, '0, "t6_newframe"));

    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (sb.size() == 0)
      n_pass++;
    else
      $display("FAIL drain: got %0d entries left, expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
